// File: rtl/inst_buffer_flow_ctrl.sv
// Instruction buffer pointer/occupancy control: compacts sparse decode lanes into
// the circular buffer, releases fixed-size dispatch groups, and paces fetch.

module inst_buffer_lane #(
    parameter int FETCH_LANES = 8,
    parameter int QLOG        = 5
) (
    input  logic [FETCH_LANES-1:0] lowerBits,
    input  logic                   laneValid,
    input  logic                   accept,
    input  logic [QLOG-1:0]        tailPtr,
    output logic                   writeEnable,
    output logic [QLOG-1:0]        writeAddr
);
    logic [QLOG-1:0] offset;

    // lowerBits holds only the valid bits of lanes below this one
    always_comb begin
        offset = '0;
        for (int j = 0; j < FETCH_LANES; j++)
            offset = offset + QLOG'(lowerBits[j]);
    end

    assign writeAddr   = tailPtr + offset;
    assign writeEnable = accept & laneValid;
endmodule

module inst_buffer_flow_ctrl #(
    parameter int INST_QUEUE     = 32,
    parameter int INST_QUEUE_LOG = 5,
    parameter int FETCH_LANES    = 8,
    parameter int DISPATCH_WIDTH = 4,
    parameter int LOW_WATER      = 16,
    parameter int FLUSH_HOLD     = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush_i,
    input  logic                                  stall_i,
    input  logic                                  decodeReady_i,
    input  logic [FETCH_LANES-1:0]                decodedVector_i,
    output logic [FETCH_LANES-1:0]                writeEnable_o,
    output logic [FETCH_LANES*INST_QUEUE_LOG-1:0] writeAddr_o,
    output logic [INST_QUEUE_LOG-1:0]             readAddrBase_o,
    output logic [INST_QUEUE_LOG:0]               instCount_o,
    output logic                                  stallFetch_o,
    output logic                                  instBufferReady_o,
    output logic                                  state_o
);
    localparam int QLOG = INST_QUEUE_LOG;
    localparam int CW   = INST_QUEUE_LOG + 1;
    localparam int HW   = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_HOLD - 1);
    localparam logic [CW:0]   DW_EXT    = (CW+1)'(DISPATCH_WIDTH);
    localparam logic [CW-1:0] HIGH_MARK = CW'(INST_QUEUE - FETCH_LANES);
    localparam logic [CW-1:0] LOW_MARK  = CW'(LOW_WATER);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t          state, stateNext;
    logic [HW-1:0]   holdCnt, holdNext;
    logic [QLOG-1:0] headPtr, headNext, tailPtr, tailNext;
    logic [CW-1:0]   instCount, countNext;
    logic            stallNext;
    logic            accept, dispatch;
    logic [CW:0]     numWrites, countSum;

    logic [FETCH_LANES-1:0][FETCH_LANES-1:0] lowerBits;
    logic [FETCH_LANES-1:0][QLOG-1:0]        laneAddr;

    // Reset gating keeps the SRAM quiet while the pointers are being forced
    assign accept   = decodeReady_i & ~stallFetch_o & ~flush_i & (state == RUN) & ~reset;
    assign instBufferReady_o = (instCount >= CW'(DISPATCH_WIDTH)) & (state == RUN) & ~reset;
    assign dispatch = instBufferReady_o & ~stall_i & ~flush_i;

    for (genvar i = 0; i < FETCH_LANES; i++) begin : g_lane
        assign lowerBits[i] = decodedVector_i & ((FETCH_LANES'(1) << i) - FETCH_LANES'(1));
        assign writeAddr_o[i*QLOG +: QLOG] = laneAddr[i];
        inst_buffer_lane #(.FETCH_LANES(FETCH_LANES), .QLOG(QLOG)) u_lane (
            .lowerBits  (lowerBits[i]),
            .laneValid  (decodedVector_i[i]),
            .accept     (accept),
            .tailPtr    (tailPtr),
            .writeEnable(writeEnable_o[i]),
            .writeAddr  (laneAddr[i])
        );
    end

    always_comb begin
        numWrites = '0;
        for (int i = 0; i < FETCH_LANES; i++)
            numWrites = numWrites + (CW+1)'(writeEnable_o[i]);
    end

    assign countSum = {1'b0, instCount} + numWrites - (dispatch ? DW_EXT : '0);

    always_comb begin
        stateNext = state;
        holdNext  = holdCnt;
        headNext  = headPtr;
        tailNext  = tailPtr;
        countNext = instCount;
        stallNext = stallFetch_o;
        if (flush_i) begin
            stateNext = HOLD;
            holdNext  = HOLD_INIT;
            headNext  = '0;
            tailNext  = '0;
            countNext = '0;
            stallNext = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    tailNext  = tailPtr + numWrites[QLOG-1:0];
                    headNext  = dispatch ? headPtr + QLOG'(DISPATCH_WIDTH) : headPtr;
                    countNext = countSum[CW-1:0];
                    // Hysteresis band between LOW_MARK and HIGH_MARK keeps the last decision
                    if (countNext > HIGH_MARK)
                        stallNext = 1'b1;
                    else if (countNext <= LOW_MARK)
                        stallNext = 1'b0;
                end
                HOLD: begin
                    if (holdCnt == '0) begin
                        stateNext = RUN;
                        stallNext = 1'b0;
                    end else begin
                        holdNext = holdCnt - HW'(1);
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            holdCnt      <= '0;
            headPtr      <= '0;
            tailPtr      <= '0;
            instCount    <= '0;
            stallFetch_o <= 1'b0;
        end else begin
            state        <= stateNext;
            holdCnt      <= holdNext;
            headPtr      <= headNext;
            tailPtr      <= tailNext;
            instCount    <= countNext;
            stallFetch_o <= stallNext;
        end
    end

    assign readAddrBase_o = headPtr;
    assign instCount_o    = instCount;
    assign state_o        = state;
endmodule

// File: doc/inst_buffer_flow_ctrl.md
INST_BUFFER_FLOW_CTRL -- requirements
Module: inst_buffer_flow_ctrl

Interface
REQ-001 SHALL have parameter INST_QUEUE, default 32, meaning buffer entries (power of two).
REQ-002 SHALL have parameter INST_QUEUE_LOG, default 5, meaning log2(INST_QUEUE).
REQ-003 SHALL have parameter FETCH_LANES, default 8, meaning write lanes per cycle (2*FETCH_BANDWIDTH).
REQ-004 SHALL have parameter DISPATCH_WIDTH, default 4, meaning entries removed per dispatch.
REQ-005 SHALL have parameter LOW_WATER, default 16, meaning stall-release threshold.
REQ-006 SHALL have parameter FLUSH_HOLD, default 2 (legal values >=1), meaning fetch-stall cycles after flush.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-009 SHALL have port flush_i, input, 1 bit: misprediction flush, synchronous.
REQ-010 SHALL have port stall_i, input, 1 bit: back-end cannot accept a dispatch group.
REQ-011 SHALL have port decodeReady_i, input, 1 bit: decode bundle present.
REQ-012 SHALL have port decodedVector_i, input, FETCH_LANES bits: per-lane valid, may be non-contiguous.
REQ-013 SHALL have port writeEnable_o, output, FETCH_LANES bits: per-lane SRAM write enable.
REQ-014 SHALL have port writeAddr_o, output, FETCH_LANES*INST_QUEUE_LOG bits: lane i address in slice i.
REQ-015 SHALL have port readAddrBase_o, output, INST_QUEUE_LOG bits: head pointer.
REQ-016 SHALL have port instCount_o, output, INST_QUEUE_LOG+1 bits: occupancy.
REQ-017 SHALL have port stallFetch_o, output, 1 bit: fetch must hold.
REQ-018 SHALL have port instBufferReady_o, output, 1 bit: dispatch group available.
REQ-019 SHALL have port state_o, output, 1 bit: 0=RUN, 1=HOLD.

Function
REQ-020 accept = decodeReady_i & ~stallFetch_o & ~flush_i & state==RUN; writeEnable_o[i] = accept & decodedVector_i[i].
REQ-021 Lane i address = tailPtr + popcount(decodedVector_i[i-1:0]), modulo INST_QUEUE (compaction, wrap-around).
REQ-022 instBufferReady_o = (instCount >= DISPATCH_WIDTH) & state==RUN, combinational.
REQ-023 dispatch = instBufferReady_o & ~stall_i & ~flush_i; on dispatch headPtr += DISPATCH_WIDTH modulo INST_QUEUE.
REQ-024 tailPtr += popcount(writeEnable_o) each cycle; writes and dispatch in the same cycle both apply.
REQ-025 instCount_next = instCount + popcount(writeEnable_o) - (dispatch ? DISPATCH_WIDTH : 0); never exceeds INST_QUEUE, never negative.
REQ-026 stallFetch_o is registered, with hysteresis on instCount_next: set when > INST_QUEUE-FETCH_LANES; cleared when <= LOW_WATER; otherwise held.
REQ-027 flush_i has priority over all same-cycle writes and dispatch; next edge: headPtr=0, tailPtr=0, instCount=0, state=HOLD, hold counter=FLUSH_HOLD-1, stallFetch_o=1.
REQ-028 HOLD: counter decrements each cycle; at counter==0 and no flush_i, next state RUN and stallFetch_o=0.
REQ-029 flush_i in HOLD reloads the counter to FLUSH_HOLD-1.
REQ-030 In HOLD, writeEnable_o=0 and instBufferReady_o=0.

Reset
REQ-031 Asserting reset asynchronously forces headPtr=0, tailPtr=0, instCount=0, stallFetch_o=0, state=RUN, hold counter=0, at any time, including mid-HOLD.
REQ-032 While reset is high, writeEnable_o=0 and instBufferReady_o=0.

Verification
REQ-033 Release reset, drive idle inputs -> all outputs 0, state_o=0.
REQ-034 stall_i=1, vector 0xFF for 4 cycles -> instCount 8,16,24,32, stallFetch_o=1 after the 4th; then stall_i=0 with no writes -> count 28,24,20,16, stallFetch_o clears on the edge where count becomes 16.
REQ-035 tailPtr=30, vector 8'b10100101 -> enables on lanes 0,2,5,7 with addresses 30,31,0,1; next tailPtr=2, count +4.
REQ-036 count=12, flush_i with stall_i=0 and vector 0x0F -> no write, no dispatch; next state HOLD, count 0, pointers 0, stallFetch_o=1 for 2 cycles, then RUN and stallFetch_o=0.
REQ-037 reset pulse during HOLD (not on a clock edge) -> state_o=0 and stallFetch_o=0 immediately.
REQ-038 count=4, stall_i=0, no writes -> dispatch, count 0, headPtr +4, instBufferReady_o=0 next cycle.
